// File: rtl/axi_sram_bridge.sv
// AXI3 slave serving one transaction at a time (single beat or burst) from a single-port SRAM.
// Define BRIDGE_WRAP_BURST_EN to enable WRAP bursts; otherwise WRAP is handled as INCR.
module axi_sram_bridge #(
    parameter int unsigned ADDR_W = 16,
    parameter logic [31:0] BASE   = 32'h1FC0_0000
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [3:0]        arid_i,
    input  logic [31:0]       araddr_i,
    input  logic [7:0]        arlen_i,
    input  logic [2:0]        arsize_i,
    input  logic [1:0]        arburst_i,
    input  logic              arvalid_i,
    output logic              arready_o,
    output logic [3:0]        rid_o,
    output logic [31:0]       rdata_o,
    output logic [1:0]        rresp_o,
    output logic              rlast_o,
    output logic              rvalid_o,
    input  logic              rready_i,
    input  logic [3:0]        awid_i,
    input  logic [31:0]       awaddr_i,
    input  logic [7:0]        awlen_i,
    input  logic [2:0]        awsize_i,
    input  logic [1:0]        awburst_i,
    input  logic              awvalid_i,
    output logic              awready_o,
    input  logic [31:0]       wdata_i,
    input  logic [3:0]        wstrb_i,
    input  logic              wlast_i,
    input  logic              wvalid_i,
    output logic              wready_o,
    output logic [3:0]        bid_o,
    output logic [1:0]        bresp_o,
    output logic              bvalid_o,
    input  logic              bready_i,
    output logic              sram_en_o,
    output logic [3:0]        sram_we_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    output logic [31:0]       sram_wdata_o,
    input  logic [31:0]       sram_rdata_i
);
    typedef enum logic [2:0] {StIdle, StRdReq, StRdData, StWrData, StWrResp} state_e;

    state_e      state_q, state_d;
    logic        last_wr_q, last_wr_d;
    logic [3:0]  id_q, id_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  len_q, len_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [1:0]  burst_q, burst_d;
    logic        err_q, err_d;
    logic        fresh_q, fresh_d;
    logic [31:0] rdata_q, rdata_d;

    logic [31:0] off, next_addr, beat_data;
    logic        oor, wrap_bad, beat_err, last_beat, grant_rd, grant_wr;
    logic        unused_ok;

    assign off       = addr_q - BASE;
    assign oor       = (addr_q < BASE) || (|off[31:ADDR_W+2]);
    assign last_beat = (cnt_q == len_q);
    assign grant_rd  = arvalid_i && (!awvalid_i || last_wr_q);
    assign grant_wr  = awvalid_i && !grant_rd;
    // err_q holds the current read beat's error, so the data is forced to zero on SLVERR
    assign beat_data = err_q ? 32'd0 : sram_rdata_i;
    assign unused_ok = ^{arsize_i, awsize_i, arlen_i[7:4], awlen_i[7:4], off[1:0]};

`ifdef BRIDGE_WRAP_BURST_EN
    logic        is_wrap;
    logic [31:0] wrap_mask;
    assign is_wrap   = (burst_q == 2'b10);
    assign wrap_bad  = is_wrap && !(len_q inside {4'd1, 4'd3, 4'd7, 4'd15});
    assign wrap_mask = (({28'd0, len_q} + 32'd1) << 2) - 32'd1;
    always_comb begin
        if (burst_q == 2'b00) begin
            next_addr = addr_q;
        end else if (is_wrap) begin
            next_addr = (addr_q & ~wrap_mask) | ((addr_q + 32'd4) & wrap_mask);
        end else begin
            next_addr = addr_q + 32'd4;
        end
    end
`else
    assign wrap_bad  = 1'b0;
    assign next_addr = (burst_q == 2'b00) ? addr_q : addr_q + 32'd4;
`endif

    assign beat_err = oor || wrap_bad;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            last_wr_q <= 1'b1;
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            burst_q   <= '0;
            err_q     <= 1'b0;
            fresh_q   <= 1'b0;
            rdata_q   <= '0;
        end else begin
            last_wr_q <= last_wr_d;
            id_q      <= id_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            burst_q   <= burst_d;
            err_q     <= err_d;
            fresh_q   <= fresh_d;
            rdata_q   <= rdata_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        last_wr_d = last_wr_q;
        id_d      = id_q;
        addr_d    = addr_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        burst_d   = burst_q;
        err_d     = err_q;
        fresh_d   = 1'b0;
        rdata_d   = rdata_q;
        unique case (state_q)
            StIdle: begin
                if (grant_rd) begin
                    id_d      = arid_i;
                    addr_d    = araddr_i;
                    len_d     = arlen_i[3:0];
                    burst_d   = arburst_i;
                    cnt_d     = '0;
                    last_wr_d = 1'b0;
                    state_d   = StRdReq;
                end else if (grant_wr) begin
                    id_d      = awid_i;
                    addr_d    = awaddr_i;
                    len_d     = awlen_i[3:0];
                    burst_d   = awburst_i;
                    cnt_d     = '0;
                    err_d     = 1'b0;
                    last_wr_d = 1'b1;
                    state_d   = StWrData;
                end
            end
            StRdReq: begin
                err_d   = beat_err;
                fresh_d = 1'b1;
                state_d = StRdData;
            end
            StRdData: begin
                // SRAM output is only valid on the first cycle; hold a copy for stalls
                if (fresh_q) begin
                    rdata_d = beat_data;
                end
                if (rready_i) begin
                    if (last_beat) begin
                        state_d = StIdle;
                    end else begin
                        cnt_d   = cnt_q + 4'd1;
                        addr_d  = next_addr;
                        state_d = StRdReq;
                    end
                end
            end
            StWrData: begin
                if (wvalid_i) begin
                    err_d  = err_q || beat_err || (wlast_i != last_beat);
                    addr_d = next_addr;
                    cnt_d  = cnt_q + 4'd1;
                    if (wlast_i || last_beat) begin
                        state_d = StWrResp;
                    end
                end
            end
            StWrResp: begin
                if (bready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        arready_o    = 1'b0;
        awready_o    = 1'b0;
        rvalid_o     = 1'b0;
        rid_o        = '0;
        rdata_o      = '0;
        rresp_o      = '0;
        rlast_o      = 1'b0;
        wready_o     = 1'b0;
        bvalid_o     = 1'b0;
        bid_o        = '0;
        bresp_o      = '0;
        sram_en_o    = 1'b0;
        sram_we_o    = '0;
        sram_addr_o  = '0;
        sram_wdata_o = '0;
        unique case (state_q)
            StIdle: begin
                arready_o = grant_rd;
                awready_o = grant_wr;
            end
            StRdReq: begin
                sram_en_o   = 1'b1;
                sram_addr_o = off[ADDR_W+1:2];
            end
            StRdData: begin
                rvalid_o = 1'b1;
                rid_o    = id_q;
                rdata_o  = fresh_q ? beat_data : rdata_q;
                rresp_o  = err_q ? 2'b10 : 2'b00;
                rlast_o  = last_beat;
            end
            StWrData: begin
                wready_o = 1'b1;
                if (wvalid_i && !beat_err) begin
                    sram_en_o    = 1'b1;
                    sram_we_o    = wstrb_i;
                    sram_addr_o  = off[ADDR_W+1:2];
                    sram_wdata_o = wdata_i;
                end
            end
            StWrResp: begin
                bvalid_o = 1'b1;
                bid_o    = id_q;
                bresp_o  = err_q ? 2'b10 : 2'b00;
            end
            default: ;
        endcase
    end
endmodule
